// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: IDLE/RUN/PAUSE/DONE control, BCD mm:ss.cc count-up/countdown,
// lap capture and live/lap display select, all outputs registered on the 100 Hz clock.
module stopwatch_core #(
  parameter logic [7:0] MM_MAX = 8'h99
) (
  input  logic       clk_db,
  input  logic       rst,
  input  logic       s0_p,
  input  logic       s1_p,
  input  logic       s2_p,
  input  logic       s3_p,
  input  logic       s4_p,
  input  logic       sw7_lvl,
  output logic [7:0] disp_mm,
  output logic [7:0] disp_ss,
  output logic [7:0] disp_cc,
  output logic       running,
  output logic       done,
  output logic       cd_mode,
  output logic       lap_view,
  output logic       lap_valid
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] mm_reg, mm_next, ss_reg, ss_next, cc_reg, cc_next;
  logic [7:0] lap_mm_reg, lap_mm_next, lap_ss_reg, lap_ss_next, lap_cc_reg, lap_cc_next;
  logic       lap_valid_reg, lap_valid_next, lap_view_reg, lap_view_next;
  logic       cd_mode_reg, cd_mode_next;
  logic [7:0] disp_mm_reg, disp_ss_reg, disp_cc_reg;
  logic       running_reg, done_reg;
  logic [7:0] step_mm, step_ss, step_cc, cand_mm;
  logic [3:0] tens;
  logic       cd_change, live_zero, show_lap;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    state_next     = state_reg;
    mm_next        = mm_reg;
    ss_next        = ss_reg;
    cc_next        = cc_reg;
    lap_mm_next    = lap_mm_reg;
    lap_ss_next    = lap_ss_reg;
    lap_cc_next    = lap_cc_reg;
    lap_valid_next = lap_valid_reg;
    lap_view_next  = lap_view_reg;
    cd_mode_next   = cd_mode_reg;
    step_mm        = mm_reg;
    step_ss        = ss_reg;
    step_cc        = cc_reg;
    tens           = 4'd0;
    cand_mm        = 8'd0;
    show_lap       = 1'b0;
    live_zero      = (mm_reg == 8'h00) && (ss_reg == 8'h00) && (cc_reg == 8'h00);
    cd_change      = (state_reg == IDLE) && (sw7_lvl != cd_mode_reg);

    if (state_reg == IDLE)
      cd_mode_next = sw7_lvl;

    // Only the highest-priority asserted pulse is considered; a mode change in IDLE
    // consumes the cycle so the new mode starts from a cleared count.
    if (s0_p) begin
      state_next     = IDLE;
      mm_next        = 8'h00;
      ss_next        = 8'h00;
      cc_next        = 8'h00;
      lap_mm_next    = 8'h00;
      lap_ss_next    = 8'h00;
      lap_cc_next    = 8'h00;
      lap_valid_next = 1'b0;
      lap_view_next  = 1'b0;
    end else if (cd_change) begin
      mm_next = 8'h00;
      ss_next = 8'h00;
      cc_next = 8'h00;
    end else if (s1_p) begin
      if ((state_reg == IDLE && !(cd_mode_reg && live_zero)) || state_reg == PAUSE)
        state_next = RUN;
    end else if (s2_p) begin
      if (state_reg == RUN)
        state_next = PAUSE;
    end else if (s3_p) begin
      if (!cd_mode_reg && (state_reg == RUN || state_reg == PAUSE)) begin
        lap_mm_next    = mm_reg;
        lap_ss_next    = ss_reg;
        lap_cc_next    = cc_reg;
        lap_valid_next = 1'b1;
      end else if (cd_mode_reg && state_reg == IDLE) begin
        mm_next = (mm_reg == MM_MAX) ? 8'h00 : bcd_inc(mm_reg);
      end
    end else if (s4_p) begin
      if (!cd_mode_reg) begin
        lap_view_next = ~lap_view_reg;
      end else if (state_reg == IDLE) begin
        tens    = (mm_reg[7:4] == 4'd9) ? 4'd0 : mm_reg[7:4] + 4'd1;
        cand_mm = {tens, mm_reg[3:0]};
        mm_next = (cand_mm > MM_MAX) ? MM_MAX : cand_mm;
      end
    end

    // Count only on edges that neither enter nor leave RUN.
    if (state_reg == RUN && state_next == RUN) begin
      if (!cd_mode_reg) begin
        if (cc_reg == 8'h99) begin
          step_cc = 8'h00;
          if (ss_reg == 8'h59) begin
            step_ss = 8'h00;
            step_mm = bcd_inc(mm_reg);
          end else begin
            step_ss = bcd_inc(ss_reg);
          end
        end else begin
          step_cc = bcd_inc(cc_reg);
        end
        if (step_mm == MM_MAX && step_ss == 8'h59 && step_cc == 8'h99)
          state_next = DONE;
      end else begin
        if (cc_reg == 8'h00) begin
          step_cc = 8'h99;
          if (ss_reg == 8'h00) begin
            step_ss = 8'h59;
            step_mm = bcd_dec(mm_reg);
          end else begin
            step_ss = bcd_dec(ss_reg);
          end
        end else begin
          step_cc = bcd_dec(cc_reg);
        end
        if (step_mm == 8'h00 && step_ss == 8'h00 && step_cc == 8'h00)
          state_next = DONE;
      end
      mm_next = step_mm;
      ss_next = step_ss;
      cc_next = step_cc;
    end

    show_lap = lap_view_next & lap_valid_next;
  end

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mm_reg        <= 8'h00;
      ss_reg        <= 8'h00;
      cc_reg        <= 8'h00;
      lap_mm_reg    <= 8'h00;
      lap_ss_reg    <= 8'h00;
      lap_cc_reg    <= 8'h00;
      lap_valid_reg <= 1'b0;
      lap_view_reg  <= 1'b0;
      cd_mode_reg   <= 1'b0;
      disp_mm_reg   <= 8'h00;
      disp_ss_reg   <= 8'h00;
      disp_cc_reg   <= 8'h00;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mm_reg        <= mm_next;
      ss_reg        <= ss_next;
      cc_reg        <= cc_next;
      lap_mm_reg    <= lap_mm_next;
      lap_ss_reg    <= lap_ss_next;
      lap_cc_reg    <= lap_cc_next;
      lap_valid_reg <= lap_valid_next;
      lap_view_reg  <= lap_view_next;
      cd_mode_reg   <= cd_mode_next;
      disp_mm_reg   <= show_lap ? lap_mm_next : mm_next;
      disp_ss_reg   <= show_lap ? lap_ss_next : ss_next;
      disp_cc_reg   <= show_lap ? lap_cc_next : cc_next;
      running_reg   <= (state_next == RUN);
      done_reg      <= (state_next == DONE);
    end
  end

  assign disp_mm   = disp_mm_reg;
  assign disp_ss   = disp_ss_reg;
  assign disp_cc   = disp_cc_reg;
  assign running   = running_reg;
  assign done      = done_reg;
  assign cd_mode   = cd_mode_reg;
  assign lap_view  = lap_view_reg;
  assign lap_valid = lap_valid_reg;

endmodule
